memory_responder: RTL and testbench
===================================

MEMORY_RESPONDER -- requirements
Module: memory_responder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 24, meaning bus data word width.
REQ-002 SHALL have parameter ADDRESS_WIDTH, default 32, meaning bus address width.
REQ-003 SHALL have parameter ID_WIDTH, default 4, meaning master ID width.
REQ-004 SHALL have parameter BASE_ADDRESS, default 0, meaning the first word address served.
REQ-005 SHALL have parameter DEPTH_LOG2, default 10, meaning log2 of the number of RAM words.
REQ-006 SHALL have parameter FIFO_DEPTH, default 4 (power of two, ≥2), meaning response queue entries.
REQ-007 SHALL have port clock, input, 1, meaning the single clock; all logic on its rising edge.
REQ-008 SHALL have port reset, input, 1, meaning asynchronous, active-low reset (0 = in reset).
REQ-009 SHALL have port bus.msValid, input, 1, meaning a master request is present.
REQ-010 SHALL have port bus.msTaken, output, 1, meaning the request is accepted this cycle.
REQ-011 SHALL have port bus.msWrite, input, 1, meaning 1 = write, 0 = read.
REQ-012 SHALL have port bus.msAddress, input, ADDRESS_WIDTH, meaning the word address.
REQ-013 SHALL have port bus.msData, input, DATA_WIDTH, meaning the write data.
REQ-014 SHALL have port bus.msID, input, ID_WIDTH, meaning the requesting master ID.
REQ-015 SHALL have port bus.smValid, output, 1, meaning read data is present.
REQ-016 SHALL have port bus.smTaken, input, 1, meaning the master consumed the read data.
REQ-017 SHALL have port bus.smData, output, DATA_WIDTH, meaning the read data.
REQ-018 SHALL have port bus.smID, output, ID_WIDTH, meaning the ID of the master that issued the read.

Function
REQ-019 SHALL treat a request as in range when BASE_ADDRESS ≤ msAddress < BASE_ADDRESS + 2^DEPTH_LOG2; RAM index = msAddress − BASE_ADDRESS, truncated to DEPTH_LOG2 bits.
REQ-020 SHALL drive msTaken combinationally = msValid && inRange && (msWrite || credit), where credit = (occupancy + inFlight) < FIFO_DEPTH.
REQ-021 SHALL never assert msTaken for an out-of-range address, leaving it for other responders.
REQ-022 An accepted write SHALL update RAM at that edge and SHALL generate no response.
REQ-023 An accepted read SHALL read RAM synchronously, register the data with msID (inFlight = 1), and push both into the response FIFO on the next edge.
REQ-024 Read latency SHALL be exactly 2 cycles: request accepted at edge E0 into an empty FIFO gives smValid = 1 in the cycle after edge E1.
REQ-025 smValid SHALL be 1 iff the FIFO is non-empty; smData/smID SHALL show the head entry, stable until popped.
REQ-026 SHALL pop the head on an edge where smValid && smTaken.
REQ-027 Push and pop on the same edge SHALL leave occupancy unchanged, with no data loss.
REQ-028 Responses SHALL be returned in acceptance order; read and write pointers wrap modulo FIFO_DEPTH.
REQ-029 When occupancy + inFlight = FIFO_DEPTH, reads SHALL stall (msTaken = 0); writes SHALL still be accepted.
REQ-030 A read accepted the cycle after a write to the same address SHALL return the new data.
REQ-031 Back-to-back reads SHALL sustain one accept per cycle while credit allows.

Reset
REQ-032 On reset = 0 (asynchronous): FIFO empty, pointers = 0, inFlight = 0, smValid = 0, smData = 0, smID = 0, msTaken = 0.
REQ-033 Reset mid-operation SHALL discard queued and in-flight reads; RAM contents are unaffected and not cleared.
REQ-034 After reset release, the first request SHALL be accepted in the first cycle it is presented.

Configuration
REQ-035 With macro MEMORY_RESPONDER_STATS_EN defined, SHALL add outputs readCount[15:0] and writeCount[15:0], each +1 per accepted read/write, wrapping at 16'hFFFF→0, reset to 0.
REQ-036 Without MEMORY_RESPONDER_STATS_EN, these ports and counters SHALL not exist; all other behaviour is identical.

Verification
REQ-037 Write 24'hABCDEF to address BASE+5, then read BASE+5 with msID=3 -> smValid 2 cycles after accept, smData=24'hABCDEF, smID=3.
REQ-038 Read address BASE+2^DEPTH_LOG2 with msValid held 10 cycles -> msTaken stays 0 and smValid stays 0.
REQ-039 Issue 6 reads to BASE+0..5 with smTaken=0 and FIFO_DEPTH=4 -> exactly 4 accepted, 5th stalls; then smTaken=1 -> data returned in order 0..3, after which the remaining reads are accepted.
REQ-040 Fill the FIFO, then hold smTaken=1 and issue continuous reads -> one accept and one pop per cycle, occupancy constant, no gaps or duplicates.
REQ-041 Assert reset=0 mid-cycle with 2 entries queued -> smValid drops immediately; after release, RAM still holds previously written data.
REQ-042 With MEMORY_RESPONDER_STATS_EN: 3 writes and 2 reads -> writeCount=3, readCount=2.

Source files
------------

// File: rtl/memory_responder_if.sv
// Request/response bus between a master and memory_responder.
// Requests flow master->slave (ms*), read responses flow slave->master (sm*).
interface memory_responder_if #(
    parameter int unsigned DATA_WIDTH    = 24,
    parameter int unsigned ADDRESS_WIDTH = 32,
    parameter int unsigned ID_WIDTH      = 4
);
    logic                     msValid;
    logic                     msTaken;
    logic                     msWrite;
    logic [ADDRESS_WIDTH-1:0] msAddress;
    logic [DATA_WIDTH-1:0]    msData;
    logic [ID_WIDTH-1:0]      msID;

    logic                     smValid;
    logic                     smTaken;
    logic [DATA_WIDTH-1:0]    smData;
    logic [ID_WIDTH-1:0]      smID;

    modport master (
        output msValid, msWrite, msAddress, msData, msID, smTaken,
        input  msTaken, smValid, smData, smID
    );

    modport slave (
        input  msValid, msWrite, msAddress, msData, msID, smTaken,
        output msTaken, smValid, smData, smID
    );
endinterface

// File: rtl/memory_responder.sv
// RAM-backed bus responder: writes land immediately, reads return in order
// through a credit-controlled response FIFO. Define MEMORY_RESPONDER_STATS_EN
// to add the readCount/writeCount statistics outputs.
module memory_responder #(
    parameter int unsigned     DATA_WIDTH    = 24,
    parameter int unsigned     ADDRESS_WIDTH = 32,
    parameter int unsigned     ID_WIDTH      = 4,
    parameter longint unsigned BASE_ADDRESS  = 0,
    parameter int unsigned     DEPTH_LOG2    = 10,
    parameter int unsigned     FIFO_DEPTH    = 4
) (
    input  logic               clock,
    input  logic               reset,
    memory_responder_if.slave  bus
`ifdef MEMORY_RESPONDER_STATS_EN
    ,
    output logic [15:0]        readCount,
    output logic [15:0]        writeCount
`endif
);

    localparam int unsigned RAM_WORDS = 1 << DEPTH_LOG2;
    localparam int unsigned PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W     = PTR_W + 1;
    localparam int unsigned AX_W      = ADDRESS_WIDTH + 1;

    typedef struct packed {
        logic [ID_WIDTH-1:0]   id;
        logic [DATA_WIDTH-1:0] data;
    } resp_t;

    // Address decode in one extra bit so BASE + span never overflows.
    logic [AX_W-1:0]       addr_ext;
    logic [AX_W-1:0]       base_ext;
    logic [AX_W-1:0]       span_ext;
    logic [AX_W-1:0]       offset;
    logic                  in_range;
    logic [DEPTH_LOG2-1:0] ram_idx;

    assign addr_ext = AX_W'(bus.msAddress);
    assign base_ext = AX_W'(BASE_ADDRESS);
    assign span_ext = AX_W'(RAM_WORDS);
    assign offset   = addr_ext - base_ext;
    assign in_range = (addr_ext >= base_ext) && (offset < span_ext);
    assign ram_idx  = offset[DEPTH_LOG2-1:0];

    // Response queue state.
    resp_t            fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] occupancy;
    logic             in_flight;
    logic [ID_WIDTH-1:0]   rd_id;
    logic [DATA_WIDTH-1:0] rd_data;

    logic credit;
    logic ms_taken_c;
    logic wr_fire;
    logic rd_fire;
    logic push;
    logic pop;
    logic sm_valid;

    // A read reserves a FIFO slot at accept time, so the in-flight read counts.
    assign credit     = (occupancy + CNT_W'(in_flight)) < CNT_W'(FIFO_DEPTH);
    assign ms_taken_c = reset && bus.msValid && in_range && (bus.msWrite || credit);
    assign wr_fire    = ms_taken_c && bus.msWrite;
    assign rd_fire    = ms_taken_c && !bus.msWrite;

    assign sm_valid   = (occupancy != '0);
    assign push       = in_flight;
    assign pop        = sm_valid && bus.smTaken;

    assign bus.msTaken = ms_taken_c;
    assign bus.smValid = sm_valid;
    assign bus.smData  = fifo_mem[rd_ptr].data;
    assign bus.smID    = fifo_mem[rd_ptr].id;

    // RAM and its read register carry no reset so contents survive a reset.
    logic [DATA_WIDTH-1:0] ram [RAM_WORDS];

    always_ff @(posedge clock) begin
        if (wr_fire) begin
            ram[ram_idx] <= bus.msData;
        end
        if (rd_fire) begin
            rd_data <= ram[ram_idx];
        end
    end

    // Read pipeline stage: tags the RAM output with the requester ID.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            in_flight <= 1'b0;
            rd_id     <= '0;
        end else begin
            in_flight <= rd_fire;
            if (rd_fire) begin
                rd_id <= bus.msID;
            end
        end
    end

    // Response FIFO; storage is cleared so the head reads zero out of reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occupancy <= '0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem[i] <= '0;
            end
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= '{id: rd_id, data: rd_data};
                wr_ptr           <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   occupancy <= occupancy + CNT_W'(1);
                2'b01:   occupancy <= occupancy - CNT_W'(1);
                default: occupancy <= occupancy;
            endcase
        end
    end

`ifdef MEMORY_RESPONDER_STATS_EN
    // Free-running transaction counters, wrapping naturally at 16 bits.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            readCount  <= '0;
            writeCount <= '0;
        end else begin
            if (rd_fire) begin
                readCount <= readCount + 16'd1;
            end
            if (wr_fire) begin
                writeCount <= writeCount + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_memory_responder.sv
// Self-checking bench for memory_responder: scenario tasks with a response
// scoreboard queue and a RAM model.
`timescale 1ns/1ps
module tb_memory_responder;

    localparam int unsigned DW         = 24;
    localparam int unsigned AW         = 32;
    localparam int unsigned IW         = 4;
    localparam int unsigned DEPTH_LOG2 = 10;
    localparam int unsigned FIFO_DEPTH = 4;
    localparam int          WORDS      = 1 << DEPTH_LOG2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;

    logic [DW-1:0]    ram_model [int];
    logic [IW+DW-1:0] sb [$];

    memory_responder_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .ID_WIDTH(IW)) bus ();

`ifdef MEMORY_RESPONDER_STATS_EN
    logic [15:0] read_count;
    logic [15:0] write_count;
`endif

    memory_responder #(
        .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .ID_WIDTH(IW),
        .BASE_ADDRESS(0), .DEPTH_LOG2(DEPTH_LOG2), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clock(clk),
        .reset(rst_n),
        .bus(bus)
`ifdef MEMORY_RESPONDER_STATS_EN
        ,
        .readCount(read_count),
        .writeCount(write_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic idle();
        bus.msValid   = 1'b0;
        bus.msWrite   = 1'b0;
        bus.msAddress = '0;
        bus.msData    = '0;
        bus.msID      = '0;
    endtask

    task automatic drive(input logic wr, input int addr, input logic [DW-1:0] d, input logic [IW-1:0] id);
        bus.msValid   = 1'b1;
        bus.msWrite   = wr;
        bus.msAddress = AW'(addr);
        bus.msData    = d;
        bus.msID      = id;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        bus.smTaken = 1'b0;
        drive(1'b0, 3, '0, 4'd1);
        repeat (2) @(negedge clk);
        total++; if (bus.smValid !== 1'b0) begin bad++; $display("FAIL reset_smValid got=%b want=0", bus.smValid); end
        total++; if (bus.smData !== '0) begin bad++; $display("FAIL reset_smData got=%h want=0", bus.smData); end
        total++; if (bus.smID !== '0) begin bad++; $display("FAIL reset_smID got=%h want=0", bus.smID); end
        total++; if (bus.msTaken !== 1'b0) begin bad++; $display("FAIL reset_msTaken got=%b want=0", bus.msTaken); end
        next_cycle();
        rst_n = 1'b1;
        drive(1'b1, 7, 24'h123456, 4'd0);
        @(negedge clk);
        total++;
        if (bus.msTaken !== 1'b1) begin bad++; $display("FAIL first_accept got=%b want=1", bus.msTaken); end
        else ram_model[7] = 24'h123456;
        next_cycle();
        idle();
    endtask

    task automatic test_preload();
        logic [DW-1:0] d;
        for (int i = 0; i < 16; i++) begin
            d = DW'($urandom);
            drive(1'b1, i, d, '0);
            @(negedge clk);
            total++;
            if (bus.msTaken !== 1'b1) begin bad++; $display("FAIL preload_taken addr=%0d got=%b want=1", i, bus.msTaken); end
            else ram_model[i] = d;
            next_cycle();
        end
        idle();
    endtask

    task automatic test_write_read();
        drive(1'b1, 5, 24'hABCDEF, '0);
        @(negedge clk);
        total++;
        if (bus.msTaken !== 1'b1) begin bad++; $display("FAIL wr5_taken got=%b want=1", bus.msTaken); end
        else ram_model[5] = 24'hABCDEF;
        next_cycle();
        drive(1'b0, 5, '0, 4'd3);
        @(negedge clk);
        total++; if (bus.msTaken !== 1'b1) begin bad++; $display("FAIL rd5_taken got=%b want=1", bus.msTaken); end
        next_cycle();
        idle();
        total++; if (bus.smValid !== 1'b0) begin bad++; $display("FAIL latency_e0 smValid got=%b want=0", bus.smValid); end
        next_cycle();
        total++; if (bus.smValid !== 1'b1) begin bad++; $display("FAIL latency_e1 smValid got=%b want=1", bus.smValid); end
        total++; if (bus.smData !== 24'hABCDEF) begin bad++; $display("FAIL rd5_data got=%h want=abcdef", bus.smData); end
        total++; if (bus.smID !== 4'd3) begin bad++; $display("FAIL rd5_id got=%0d want=3", bus.smID); end
        next_cycle();
        total++;
        if (bus.smValid !== 1'b1 || bus.smData !== 24'hABCDEF) begin
            bad++; $display("FAIL head_hold valid=%b data=%h want 1/abcdef", bus.smValid, bus.smData);
        end
        bus.smTaken = 1'b1;
        next_cycle();
        bus.smTaken = 1'b0;
        total++; if (bus.smValid !== 1'b0) begin bad++; $display("FAIL pop_empty smValid got=%b want=0", bus.smValid); end
    endtask

    task automatic test_out_of_range();
        drive(1'b0, WORDS, '0, 4'd2);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            total++; if (bus.msTaken !== 1'b0) begin bad++; $display("FAIL oor_taken cyc=%0d got=%b want=0", c, bus.msTaken); end
            total++; if (bus.smValid !== 1'b0) begin bad++; $display("FAIL oor_smValid cyc=%0d got=%b want=0", c, bus.smValid); end
            next_cycle();
        end
        drive(1'b1, WORDS - 1, 24'h5A5A5A, '0);
        @(negedge clk);
        total++;
        if (bus.msTaken !== 1'b1) begin bad++; $display("FAIL top_wr_taken got=%b want=1", bus.msTaken); end
        else ram_model[WORDS - 1] = 24'h5A5A5A;
        next_cycle();
        drive(1'b0, WORDS - 1, '0, 4'd9);
        @(negedge clk);
        total++; if (bus.msTaken !== 1'b1) begin bad++; $display("FAIL top_rd_taken got=%b want=1", bus.msTaken); end
        next_cycle();
        idle();
        next_cycle();
        total++;
        if ({bus.smValid, bus.smID, bus.smData} !== {1'b1, 4'd9, 24'h5A5A5A}) begin
            bad++; $display("FAIL top_rd_resp valid=%b id=%0d data=%h want 1/9/5a5a5a", bus.smValid, bus.smID, bus.smData);
        end
        bus.smTaken = 1'b1;
        next_cycle();
        bus.smTaken = 1'b0;
    endtask

    task automatic test_backpressure();
        int n = 0;
        int cyc = 0;
        logic [IW+DW-1:0] exp;
        bus.smTaken = 1'b0;
        sb.delete();
        for (int c = 0; c < 10; c++) begin
            if (n < 6) drive(1'b0, n, '0, IW'(n)); else idle();
            @(negedge clk);
            if (bus.msTaken === 1'b1) begin sb.push_back({IW'(n), ram_model[n]}); n++; end
            next_cycle();
        end
        total++; if (n != 4) begin bad++; $display("FAIL bp_accepted got=%0d want=4", n); end
        @(negedge clk);
        total++; if (bus.msTaken !== 1'b0) begin bad++; $display("FAIL bp_stall got=%b want=0", bus.msTaken); end
        next_cycle();
        bus.smTaken = 1'b1;
        while ((n < 6 || sb.size() != 0) && cyc < 40) begin
            if (n < 6) drive(1'b0, n, '0, IW'(n)); else idle();
            @(negedge clk);
            if (bus.smValid === 1'b1) begin
                total++;
                if (sb.size() == 0) begin bad++; $display("FAIL bp_extra id=%0d data=%h want none", bus.smID, bus.smData); end
                else begin
                    exp = sb.pop_front();
                    if ({bus.smID, bus.smData} !== exp) begin
                        bad++; $display("FAIL bp_order got=%h want=%h", {bus.smID, bus.smData}, exp);
                    end
                end
            end
            if (bus.msTaken === 1'b1 && n < 6) begin sb.push_back({IW'(n), ram_model[n]}); n++; end
            next_cycle();
            cyc++;
        end
        total++;
        if (n != 6 || sb.size() != 0) begin bad++; $display("FAIL bp_drain accepted=%0d pending=%0d want 6/0", n, sb.size()); end
        idle();
        bus.smTaken = 1'b0;
    endtask

    task automatic test_back_to_back();
        int n = 0;
        int m = 0;
        int cyc = 0;
        int first = -1;
        int last = -1;
        int gaps = 0;
        logic [IW+DW-1:0] exp;
        bus.smTaken = 1'b0;
        sb.delete();
        while (n < 4 && cyc < 20) begin
            drive(1'b0, 8 + n, '0, IW'(n));
            @(negedge clk);
            if (bus.msTaken === 1'b1) begin sb.push_back({IW'(n), ram_model[8 + n]}); n++; end
            next_cycle();
            cyc++;
        end
        idle();
        next_cycle();
        next_cycle();
        total++; if (bus.smValid !== 1'b1 || n != 4) begin bad++; $display("FAIL b2b_fill valid=%b accepted=%0d want 1/4", bus.smValid, n); end
        bus.smTaken = 1'b1;
        cyc = 0;
        while ((m < 12 || sb.size() != 0) && cyc < 80) begin
            if (m < 12) drive(1'b0, m, '0, IW'(m + 4)); else idle();
            @(negedge clk);
            if (bus.smValid === 1'b1) begin
                total++;
                if (sb.size() == 0) begin bad++; $display("FAIL b2b_extra id=%0d data=%h want none", bus.smID, bus.smData); end
                else begin
                    exp = sb.pop_front();
                    if ({bus.smID, bus.smData} !== exp) begin
                        bad++; $display("FAIL b2b_order got=%h want=%h", {bus.smID, bus.smData}, exp);
                    end
                end
            end else if (first >= 0 && m < 12) begin
                gaps++;
            end
            if (bus.msTaken === 1'b1 && m < 12) begin
                sb.push_back({IW'(m + 4), ram_model[m]});
                if (first < 0) first = cyc;
                last = cyc;
                m++;
            end
            next_cycle();
            cyc++;
        end
        total++; if (last - first != 11) begin bad++; $display("FAIL b2b_rate span=%0d want=11", last - first); end
        total++; if (gaps != 0) begin bad++; $display("FAIL b2b_gaps got=%0d want=0", gaps); end
        total++; if (m != 12 || sb.size() != 0) begin bad++; $display("FAIL b2b_drain accepted=%0d pending=%0d want 12/0", m, sb.size()); end
        idle();
        bus.smTaken = 1'b0;
    endtask

    task automatic test_reset_mid();
        int addrs [2] = '{5, 7};
        bus.smTaken = 1'b0;
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, addrs[i], '0, IW'(i + 1));
            @(negedge clk);
            total++; if (bus.msTaken !== 1'b1) begin bad++; $display("FAIL rm_taken idx=%0d got=%b want=1", i, bus.msTaken); end
            next_cycle();
        end
        idle();
        next_cycle();
        next_cycle();
        @(negedge clk);
        total++; if (bus.smValid !== 1'b1) begin bad++; $display("FAIL rm_queued got=%b want=1", bus.smValid); end
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (bus.smValid !== 1'b0) begin bad++; $display("FAIL rm_drop smValid got=%b want=0", bus.smValid); end
        sb.delete();
        next_cycle();
        next_cycle();
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, addrs[i], '0, 4'd6);
            @(negedge clk);
            total++; if (bus.msTaken !== 1'b1) begin bad++; $display("FAIL rm_reread_taken idx=%0d got=%b want=1", i, bus.msTaken); end
            next_cycle();
            idle();
            next_cycle();
            total++;
            if (bus.smValid !== 1'b1 || bus.smData !== ram_model[addrs[i]]) begin
                bad++; $display("FAIL rm_ram_kept addr=%0d valid=%b data=%h want 1/%h", addrs[i], bus.smValid, bus.smData, ram_model[addrs[i]]);
            end
            bus.smTaken = 1'b1;
            next_cycle();
            bus.smTaken = 1'b0;
        end
    endtask

`ifdef MEMORY_RESPONDER_STATS_EN
    task automatic test_stats();
        rst_n = 1'b0;
        next_cycle();
        rst_n = 1'b1;
        total++; if (read_count !== 16'd0 || write_count !== 16'd0) begin bad++; $display("FAIL stats_reset rd=%0d wr=%0d want 0/0", read_count, write_count); end
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 20 + i, DW'(i + 1), '0);
            @(negedge clk);
            if (bus.msTaken === 1'b1) ram_model[20 + i] = DW'(i + 1);
            next_cycle();
        end
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 20 + i, '0, '0);
            next_cycle();
        end
        idle();
        next_cycle();
        total++; if (write_count !== 16'd3) begin bad++; $display("FAIL stats_write got=%0d want=3", write_count); end
        total++; if (read_count !== 16'd2) begin bad++; $display("FAIL stats_read got=%0d want=2", read_count); end
        bus.smTaken = 1'b1;
        repeat (3) next_cycle();
        bus.smTaken = 1'b0;
    endtask
`endif

    initial begin
        idle();
        bus.smTaken = 1'b0;
        test_reset();
        test_preload();
        test_write_read();
        test_out_of_range();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
`ifdef MEMORY_RESPONDER_STATS_EN
        test_stats();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
